key_entry: RTL

- Front-end digit entry stage for the 4-digit password lock.
- Debounces the enter and cancel push-buttons, then captures the 4-bit switch value as one password digit per enter press.
- Emits each digit with a single-cycle `step` qualifier that the downstream sequence checker uses as its advance enable.
- Tracks entry position, abandons stale entries on inactivity, and generates the downstream sequence-clear pulse.

---
 rtl/key_entry.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/key_entry.sv
// Password-lock digit entry: debounces enter/cancel, captures one 4-bit digit per
// enter press, tracks entry position and abandons stale partial entries.

module key_entry_db #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 11
) (
    input  logic clk,
    input  logic clr,
    input  logic btn_i,
    output logic press_o
);
    logic             sync1_q, sync2_q;
    logic             vld1_q, vld2_q;
    logic             deb_q, deb_d;
    logic             prev_q;
    logic             arm_q, arm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            deb_d = ~deb_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        // A button held through reset must be seen released before it can
        // produce a press; vld tracks when the synchronizer holds real samples.
        arm_d = arm_q | (vld2_q & ~sync2_q & ~deb_q);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            vld1_q  <= 1'b0;
            vld2_q  <= 1'b0;
            deb_q   <= 1'b0;
            prev_q  <= 1'b0;
            arm_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            vld1_q  <= 1'b1;
            vld2_q  <= vld1_q;
            deb_q   <= deb_d;
            prev_q  <= deb_q;
            arm_q   <= arm_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = deb_q & ~prev_q & arm_q;
endmodule

module key_entry #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int CNT_W           = 11
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] sw,
    input  logic       btn_enter,
    input  logic       btn_cancel,
    output logic [3:0] pw,
    output logic       step,
    output logic       done,
    output logic       seq_clr,
    output logic [2:0] digit_cnt
);
    logic [1:0]       btn;
    logic [1:0]       press;
    logic             enter_ev, cancel_ev;
    logic [3:0]       pw_q, pw_d;
    logic             step_q, step_d;
    logic             done_q, done_d;
    logic             seq_clr_q, seq_clr_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;

    assign btn = {btn_cancel, btn_enter};

    generate
        for (genvar i = 0; i < 2; i++) begin : g_db
            key_entry_db #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_db (
                .clk    (clk),
                .clr    (clr),
                .btn_i  (btn[i]),
                .press_o(press[i])
            );
        end
    endgenerate

    // Cancel dominates a coincident enter.
    assign cancel_ev = press[1];
    assign enter_ev  = press[0] & ~press[1];

    always_comb begin
        pw_d      = pw_q;
        step_d    = 1'b0;
        done_d    = 1'b0;
        seq_clr_d = 1'b0;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        if (cancel_ev) begin
            seq_clr_d = 1'b1;
            cnt_d     = 3'd0;
            tmo_d     = '0;
        end else if (enter_ev) begin
            pw_d   = sw;
            step_d = 1'b1;
            tmo_d  = '0;
            if (cnt_q == 3'd3) begin
                done_d = 1'b1;
                cnt_d  = 3'd0;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end else if (cnt_q != 3'd0) begin
            if (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                seq_clr_d = 1'b1;
                cnt_d     = 3'd0;
                tmo_d     = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            pw_q      <= 4'd0;
            step_q    <= 1'b0;
            done_q    <= 1'b0;
            seq_clr_q <= 1'b0;
            cnt_q     <= 3'd0;
            tmo_q     <= '0;
        end else begin
            pw_q      <= pw_d;
            step_q    <= step_d;
            done_q    <= done_d;
            seq_clr_q <= seq_clr_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    assign pw        = pw_q;
    assign step      = step_q;
    assign done      = done_q;
    assign seq_clr   = seq_clr_q;
    assign digit_cnt = cnt_q;
endmodule
